// File: rtl/icache_assoc_registers_if.sv
// Fetch-lookup, refill and invalidate signals of the set-associative icache storage.
// The requester (fetch/refill controller side) uses master; the cache array uses slave.
interface icache_assoc_registers_if #(
  parameter int unsigned offset_width = 2,
  parameter int unsigned line_width   = 6,
  parameter int unsigned ways         = 2
);
  localparam int unsigned way_bits  = (ways > 1) ? $clog2(ways) : 1;
  localparam int unsigned tag_width = 32 - offset_width - line_width - 2;

  logic [31:0]           address;
  logic                  lookup_valid;
  logic [31:0]           instruction;
  logic                  hit;
  logic [way_bits-1:0]   hit_way;
  logic                  refill_start;
  logic [line_width-1:0] refill_line;
  logic [tag_width-1:0]  refill_tag;
  logic [31:0]           refill_data;
  logic                  refill_valid;
  logic                  refill_ready;
  logic                  refill_done;
  logic                  invalidate_all;
  logic                  busy;

  modport master (
    output address, lookup_valid, refill_start, refill_line, refill_tag,
           refill_data, refill_valid, invalidate_all,
    input  instruction, hit, hit_way, refill_ready, refill_done, busy
  );

  modport slave (
    input  address, lookup_valid, refill_start, refill_line, refill_tag,
           refill_data, refill_valid, invalidate_all,
    output instruction, hit, hit_way, refill_ready, refill_done, busy
  );
endinterface

// File: rtl/icache_assoc_registers.sv
// Set-associative icache storage: combinational lookup, multi-beat line refill, sequenced invalidate sweep.
// Define ICACHE_PLRU_EN for tree pseudo-LRU replacement; default is per-set round-robin.
module icache_assoc_registers #(
  parameter int unsigned offset_width = 2,
  parameter int unsigned line_width   = 6,
  parameter int unsigned ways         = 2
) (
  input logic                     clock,
  input logic                     reset,
  icache_assoc_registers_if.slave bus
);
  localparam int unsigned block_size  = 1 << offset_width;
  localparam int unsigned cache_depth = 1 << line_width;
  localparam int unsigned way_bits    = (ways > 1) ? $clog2(ways) : 1;
  localparam int unsigned tag_width   = 32 - offset_width - line_width - 2;

  typedef enum logic [1:0] {IDLE, FILL, INVAL} state_t;

  state_t                  state_q, state_d;
  logic [offset_width-1:0] beat_q, beat_d;
  logic [line_width-1:0]   sweep_q, sweep_d;
  logic [line_width-1:0]   line_q, line_d;
  logic [tag_width-1:0]    rtag_q, rtag_d;
  logic [way_bits-1:0]     victim_q, victim_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic [cache_depth-1:0]  valid_q [ways];
  logic [cache_depth-1:0]  valid_d [ways];

  logic [31:0]             data_q [ways][cache_depth][block_size];
  logic [tag_width-1:0]    tag_q  [ways][cache_depth];
  logic                    data_we, commit;

  logic [line_width-1:0]   lk_set;
  logic [offset_width-1:0] lk_word;
  logic [tag_width-1:0]    lk_tag;
  logic                    hit_c;
  logic [way_bits-1:0]     way_c;
  logic [31:0]             instr_c;
  logic [way_bits-1:0]     pick;
  logic [way_bits-1:0]     repl_pick;
  logic                    pick_found;

`ifdef ICACHE_PLRU_EN
  localparam int unsigned lvls   = $clog2(ways);
  localparam int unsigned plru_w = (ways > 1) ? ways - 1 : 1;

  logic [plru_w-1:0] plru_q [cache_depth];
  logic [plru_w-1:0] plru_d [cache_depth];
  logic [1:0]        unused_addr_lsb;
  assign unused_addr_lsb = bus.address[1:0];

  // Heap-ordered tree: each node bit points toward the subtree holding the next victim.
  function automatic logic [plru_w-1:0] plru_touch(input logic [plru_w-1:0] bits,
                                                   input logic [way_bits-1:0] way);
    logic [plru_w-1:0] b;
    int unsigned       node;
    b    = bits;
    node = 1;
    for (int unsigned l = 0; l < lvls; l++) begin
      b[node-1] = ~way[lvls-1-l];
      node      = 2 * node + 32'(way[lvls-1-l]);
    end
    return b;
  endfunction

  function automatic logic [way_bits-1:0] plru_leaf(input logic [plru_w-1:0] bits);
    int unsigned node;
    node = 1;
    for (int unsigned l = 0; l < lvls; l++) node = 2 * node + 32'(bits[node-1]);
    return way_bits'(node - ways);
  endfunction

  assign repl_pick = plru_leaf(plru_q[bus.refill_line]);
`else
  logic [way_bits-1:0] rr_q [cache_depth];
  logic [way_bits-1:0] rr_d [cache_depth];
  logic [2:0]          unused_bits;
  assign unused_bits = {bus.lookup_valid, bus.address[1:0]};
  assign repl_pick   = rr_q[bus.refill_line];
`endif

  assign lk_set  = bus.address[line_width+offset_width+1 : offset_width+2];
  assign lk_word = bus.address[offset_width+1 : 2];
  assign lk_tag  = bus.address[31 : line_width+offset_width+2];

  always_comb begin
    hit_c   = 1'b0;
    way_c   = '0;
    instr_c = '0;
    for (int unsigned w = 0; w < ways; w++) begin
      if (!hit_c && valid_q[w][lk_set] && tag_q[w][lk_set] == lk_tag) begin
        hit_c   = 1'b1;
        way_c   = way_bits'(w);
        instr_c = data_q[w][lk_set][lk_word];
      end
    end
  end

  assign bus.hit          = hit_c;
  assign bus.hit_way      = way_c;
  assign bus.instruction  = instr_c;
  assign bus.refill_ready = ready_q;
  assign bus.refill_done  = done_q;
  assign bus.busy         = (state_q != IDLE);

  always_comb begin
    pick       = repl_pick;
    pick_found = 1'b0;
    for (int unsigned w = 0; w < ways; w++) begin
      if (!pick_found && !valid_q[w][bus.refill_line]) begin
        pick       = way_bits'(w);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    sweep_d  = sweep_q;
    line_d   = line_q;
    rtag_d   = rtag_q;
    victim_d = victim_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    data_we  = 1'b0;
    commit   = 1'b0;
`ifdef ICACHE_PLRU_EN
    plru_d = plru_q;
    // Lookup touch is applied first so a same-set commit below overrides it.
    if (bus.lookup_valid && hit_c) plru_d[lk_set] = plru_touch(plru_q[lk_set], way_c);
`else
    rr_d = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.invalidate_all) begin
          state_d = INVAL;
          sweep_d = '0;
        end else if (bus.refill_start) begin
          line_d                         = bus.refill_line;
          rtag_d                         = bus.refill_tag;
          victim_d                       = pick;
          valid_d[pick][bus.refill_line] = 1'b0;
          beat_d                         = '0;
          state_d                        = FILL;
        end
      end
      FILL: begin
        if (bus.invalidate_all) begin
          state_d = INVAL;
          sweep_d = '0;
        end else if (bus.refill_valid && ready_q) begin
          data_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == offset_width'(block_size - 1)) begin
            commit                   = 1'b1;
            valid_d[victim_q][line_q] = 1'b1;
            done_d                   = 1'b1;
            state_d                  = IDLE;
`ifdef ICACHE_PLRU_EN
            plru_d[line_q] = plru_touch(plru_q[line_q], victim_q);
`else
            rr_d[line_q] = (rr_q[line_q] == way_bits'(ways - 1)) ? '0 : rr_q[line_q] + 1'b1;
`endif
          end
        end
      end
      INVAL: begin
        for (int unsigned w = 0; w < ways; w++) valid_d[w][sweep_q] = 1'b0;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == line_width'(cache_depth - 1)) begin
          state_d = IDLE;
`ifdef ICACHE_PLRU_EN
          plru_d = '{default: '0};
`else
          rr_d = '{default: '0};
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == FILL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      sweep_q  <= '0;
      line_q   <= '0;
      rtag_q   <= '0;
      victim_q <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= '{default: '0};
`ifdef ICACHE_PLRU_EN
      plru_q   <= '{default: '0};
`else
      rr_q     <= '{default: '0};
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      sweep_q  <= sweep_d;
      line_q   <= line_d;
      rtag_q   <= rtag_d;
      victim_q <= victim_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
`ifdef ICACHE_PLRU_EN
      plru_q   <= plru_d;
`else
      rr_q     <= rr_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (data_we) data_q[victim_q][line_q][beat_q] <= bus.refill_data;
    if (commit)  tag_q[victim_q][line_q]          <= rtag_q;
  end
endmodule

// File: tb/tb_icache_assoc_registers.sv
// Self-checking bench for icache_assoc_registers: lookup vectors via a scoreboard queue plus refill/invalidate/reset sequences.
module tb_icache_assoc_registers;
  localparam int unsigned OW = 2;
  localparam int unsigned LW = 6;
  localparam int unsigned WAYS = 2;
  localparam int unsigned TW = 32 - OW - LW - 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  icache_assoc_registers_if #(.offset_width(OW), .line_width(LW), .ways(WAYS)) bus_if ();
  icache_assoc_registers #(.offset_width(OW), .line_width(LW), .ways(WAYS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        hit;
    logic [0:0]  way;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        hit;
    logic [0:0]  way;
    logic [31:0] instr;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  function automatic logic [31:0] mk_addr(input logic [TW-1:0] tag, input logic [LW-1:0] set,
                                          input logic [OW-1:0] word);
    return {tag, set, word, 2'b00};
  endfunction

  function automatic logic [31:0] beat_word(input logic [31:0] base, input int b);
    return base * (b + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vecs();
    exp_t e;
    foreach (vecs[i]) begin
      bus_if.address = vecs[i].addr;
      exp_q.push_back('{vecs[i].hit, vecs[i].way, vecs[i].instr});
      @(negedge clock);
      e = exp_q.pop_front();
      check({vecs[i].name, " hit"}, 32'(bus_if.hit), 32'(e.hit));
      check({vecs[i].name, " way"}, 32'(bus_if.hit_way), 32'(e.way));
      check({vecs[i].name, " instr"}, bus_if.instruction, e.instr);
    end
    vecs.delete();
  endtask

  task automatic refill(input string name, input logic [LW-1:0] line, input logic [TW-1:0] tag,
                        input logic [31:0] base, input int gap_after);
    bus_if.refill_start = 1'b1;
    bus_if.refill_line  = line;
    bus_if.refill_tag   = tag;
    tick();
    bus_if.refill_start = 1'b0;
    check({name, " ready first FILL cycle"}, 32'(bus_if.refill_ready), 32'd1);
    for (int b = 0; b < 4; b++) begin
      bus_if.refill_valid = 1'b1;
      bus_if.refill_data  = beat_word(base, b);
      tick();
      bus_if.refill_valid = 1'b0;
      if (b < 3) check({name, " no early done"}, 32'(bus_if.refill_done), 32'd0);
      if (b == gap_after) begin
        tick();
        check({name, " ready in gap"}, 32'(bus_if.refill_ready), 32'd1);
      end
    end
    check({name, " done pulse"}, 32'(bus_if.refill_done), 32'd1);
    check({name, " ready after commit"}, 32'(bus_if.refill_ready), 32'd0);
    tick();
    check({name, " done one cycle"}, 32'(bus_if.refill_done), 32'd0);
  endtask

  localparam logic [31:0] BA = 32'h0000_0011;
  localparam logic [31:0] BB = 32'h0B00_0000;
  localparam logic [31:0] BC = 32'h0C00_0000;
  localparam logic [31:0] BD = 32'h0D00_0000;

  initial begin
    int  cnt;
    logic saw_done, saw_ready;

    reset                 = 1'b1;
    bus_if.address        = 32'h0000_0100;
    bus_if.lookup_valid   = 1'b0;
    bus_if.refill_start   = 1'b0;
    bus_if.refill_line    = '0;
    bus_if.refill_tag     = '0;
    bus_if.refill_data    = '0;
    bus_if.refill_valid   = 1'b0;
    bus_if.invalidate_all = 1'b0;
    #12;
    check("reset hit", 32'(bus_if.hit), 32'd0);
    check("reset instr", bus_if.instruction, 32'd0);
    check("reset busy", 32'(bus_if.busy), 32'd0);
    check("reset ready", 32'(bus_if.refill_ready), 32'd0);
    check("reset done", 32'(bus_if.refill_done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    refill("fill A", 6'd0, 22'h1234, BA, 1);
    vecs.push_back('{"A w2", mk_addr(22'h1234, 6'd0, 2'd2), 1'b1, 1'b0, 32'h33});
    vecs.push_back('{"A w0", mk_addr(22'h1234, 6'd0, 2'd0), 1'b1, 1'b0, 32'h11});
    run_vecs();

    refill("fill B", 6'd0, 22'h5678, BB, -1);
    vecs.push_back('{"A w2 two-way", mk_addr(22'h1234, 6'd0, 2'd2), 1'b1, 1'b0, 32'h33});
    vecs.push_back('{"B w0", mk_addr(22'h5678, 6'd0, 2'd0), 1'b1, 1'b1, beat_word(BB, 0)});
    vecs.push_back('{"B w3", mk_addr(22'h5678, 6'd0, 2'd3), 1'b1, 1'b1, beat_word(BB, 3)});
    run_vecs();

    refill("fill C", 6'd0, 22'h9ABC, BC, -1);
    refill("fill D", 6'd63, 22'h3FFFFF, BD, -1);
    vecs.push_back('{"A evicted", mk_addr(22'h1234, 6'd0, 2'd2), 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"B w1", mk_addr(22'h5678, 6'd0, 2'd1), 1'b1, 1'b1, beat_word(BB, 1)});
    vecs.push_back('{"C w0", mk_addr(22'h9ABC, 6'd0, 2'd0), 1'b1, 1'b0, beat_word(BC, 0)});
    vecs.push_back('{"C w3", mk_addr(22'h9ABC, 6'd0, 2'd3), 1'b1, 1'b0, beat_word(BC, 3)});
    vecs.push_back('{"D set63 w3", mk_addr(22'h3FFFFF, 6'd63, 2'd3), 1'b1, 1'b0, beat_word(BD, 3)});
    vecs.push_back('{"other set", mk_addr(22'h5678, 6'd1, 2'd0), 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"wrong tag", mk_addr(22'h5679, 6'd0, 2'd0), 1'b0, 1'b0, 32'h0});
    run_vecs();

    // Full invalidate; invalidate_all held a few cycles and a refill_start raised while busy.
    bus_if.invalidate_all = 1'b1;
    tick();
    cnt = 0; saw_done = 1'b0; saw_ready = 1'b0;
    while (bus_if.busy && cnt < 200) begin
      cnt++;
      if (cnt == 3) begin
        bus_if.invalidate_all = 1'b0;
        bus_if.address = mk_addr(22'h5678, 6'd0, 2'd0);
        #1 check("swept set 0 misses", 32'(bus_if.hit), 32'd0);
        bus_if.address = mk_addr(22'h3FFFFF, 6'd63, 2'd3);
        #1 check("unswept set 63 hits", 32'(bus_if.hit), 32'd1);
      end
      if (cnt == 5) begin
        bus_if.refill_start = 1'b1;
        bus_if.refill_line  = 6'd5;
        bus_if.refill_tag   = 22'h777;
      end
      if (cnt == 20) bus_if.refill_start = 1'b0;
      if (bus_if.refill_ready) saw_ready = 1'b1;
      if (bus_if.refill_done) saw_done = 1'b1;
      tick();
    end
    bus_if.refill_start = 1'b0;
    bus_if.invalidate_all = 1'b0;
    check("inval busy cycles", 32'(cnt), 32'd64);
    check("inval no ready", 32'(saw_ready), 32'd0);
    check("inval no done", 32'(saw_done), 32'd0);
    tick();
    check("post inval idle", 32'(bus_if.busy), 32'd0);
    check("post inval no fill", 32'(bus_if.refill_ready), 32'd0);
    vecs.push_back('{"inv B", mk_addr(22'h5678, 6'd0, 2'd0), 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"inv C", mk_addr(22'h9ABC, 6'd0, 2'd3), 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"inv D", mk_addr(22'h3FFFFF, 6'd63, 2'd3), 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"busy start ignored", mk_addr(22'h777, 6'd5, 2'd0), 1'b0, 1'b0, 32'h0});
    run_vecs();

    // Abort a fill after two accepted beats.
    bus_if.refill_start = 1'b1;
    bus_if.refill_line  = 6'd2;
    bus_if.refill_tag   = 22'h2222;
    tick();
    bus_if.refill_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus_if.refill_valid = 1'b1;
      bus_if.refill_data  = beat_word(32'h0E00_0000, b);
      tick();
    end
    bus_if.refill_valid = 1'b0;
    bus_if.invalidate_all = 1'b1;
    tick();
    bus_if.invalidate_all = 1'b0;
    check("abort ready drops", 32'(bus_if.refill_ready), 32'd0);
    check("abort busy", 32'(bus_if.busy), 32'd1);
    cnt = 0; saw_done = 1'b0;
    while (bus_if.busy && cnt < 200) begin
      cnt++;
      if (bus_if.refill_done) saw_done = 1'b1;
      tick();
    end
    check("abort sweep cycles", 32'(cnt), 32'd64);
    check("abort no done", 32'(saw_done), 32'd0);
    vecs.push_back('{"aborted w0", mk_addr(22'h2222, 6'd2, 2'd0), 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"aborted w1", mk_addr(22'h2222, 6'd2, 2'd1), 1'b0, 1'b0, 32'h0});
    run_vecs();

    // Asynchronous reset in the middle of a fill.
    refill("fill R", 6'd9, 22'h99, 32'h0900_0000, -1);
    bus_if.address = mk_addr(22'h99, 6'd9, 2'd1);
    #1 check("pre-reset hit", 32'(bus_if.hit), 32'd1);
    bus_if.refill_start = 1'b1;
    bus_if.refill_line  = 6'd7;
    bus_if.refill_tag   = 22'h77;
    tick();
    bus_if.refill_start = 1'b0;
    bus_if.refill_valid = 1'b1;
    bus_if.refill_data  = 32'hDEAD_0001;
    tick();
    bus_if.refill_valid = 1'b0;
    check("mid-fill ready", 32'(bus_if.refill_ready), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset ready", 32'(bus_if.refill_ready), 32'd0);
    check("async reset hit", 32'(bus_if.hit), 32'd0);
    check("async reset instr", bus_if.instruction, 32'd0);
    check("async reset busy", 32'(bus_if.busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("after reset idle", 32'(bus_if.busy), 32'd0);
    check("after reset ready", 32'(bus_if.refill_ready), 32'd0);
    check("after reset done", 32'(bus_if.refill_done), 32'd0);

`ifdef ICACHE_PLRU_EN
    refill("plru fill 0", 6'd3, 22'h1, 32'h0100_0000, -1);
    refill("plru fill 1", 6'd3, 22'h2, 32'h0200_0000, -1);
    bus_if.address      = mk_addr(22'h1, 6'd3, 2'd0);
    bus_if.lookup_valid = 1'b1;
    @(negedge clock);
    check("plru touch hit", 32'(bus_if.hit), 32'd1);
    check("plru touch way", 32'(bus_if.hit_way), 32'd0);
    tick();
    bus_if.lookup_valid = 1'b0;
    refill("plru fill 2", 6'd3, 22'h3, 32'h0300_0000, -1);
    vecs.push_back('{"plru victim way1", mk_addr(22'h3, 6'd3, 2'd2), 1'b1, 1'b1, beat_word(32'h0300_0000, 2)});
    vecs.push_back('{"plru kept way0", mk_addr(22'h1, 6'd3, 2'd1), 1'b1, 1'b0, beat_word(32'h0100_0000, 1)});
    vecs.push_back('{"plru evicted", mk_addr(22'h2, 6'd3, 2'd1), 1'b0, 1'b0, 32'h0});
    run_vecs();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_assoc_registers.md
Name: icache_assoc_registers

Overview:
- Set-associative successor to the direct-mapped instruction-cache storage array. It holds `ways` ways of `2^line_width` sets, each line `2^offset_width` instructions wide.
- Lookup is combinational. Each line is filled by a multi-beat refill handshake from the refill/memory side.
- Victim selection and line allocation happen inside the block. Full invalidation is a sequenced sweep.
- Sits between the fetch stage (lookup) and the icache refill controller (fill port).

Parameters:
- offset_width, 2, log2 of instructions per line; block_size = 1<<offset_width.
- line_width, 6, log2 of sets; cache_depth = 1<<line_width.
- ways, 2, associativity; power of two, 1..8; way_bits = max(1, clog2(ways)).
- Derived, not overridable: tag_width = 32-offset_width-line_width-2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  32  fetch address; set = address[line_width+offset_width+1 : offset_width+2], word = address[offset_width+1:2], tag = address[31 : line_width+offset_width+2]
- lookup_valid  in  1  address is a real fetch (replacement-state update only)
- instruction  out  32  word from the hitting way; 0 on miss
- hit  out  1  some valid way in the set has a matching tag
- hit_way  out  way_bits  index of the hitting way; 0 on miss
- refill_start  in  1  begin a line fill
- refill_line  in  line_width  set to fill
- refill_tag  in  tag_width  tag of the incoming line
- refill_data  in  32  one instruction per beat, word 0 first
- refill_valid  in  1  beat present
- refill_ready  out  1  block accepts beat
- refill_done  out  1  one-cycle pulse, line committed
- invalidate_all  in  1  clear all valid bits
- busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; all valid bits 0; replacement state 0; refill_ready=0; refill_done=0; counters 0. The data and tag arrays are not reset. hit=0 and instruction=0 immediately.
- Lookup is purely combinational from address. At most one way may match, because the requester never refills a tag already resident. Lookup stays operational in every state.
- FSM states: IDLE, FILL, INVAL.
- IDLE:
  - If invalidate_all is high, go to INVAL. This has priority over a simultaneous refill_start.
  - Else if refill_start is high:
    - Latch refill_line and refill_tag.
    - Choose the victim: the lowest-index invalid way of the set, else the replacement choice.
    - Clear the victim's valid bit on this same edge. A partially filled line never hits.
    - Set beat counter=0 and go to FILL.
- FILL:
  - refill_ready=1, registered; it is high from the first FILL cycle.
  - Each cycle with refill_valid&&refill_ready, write refill_data to data[victim][line][beat] and increment beat.
  - Gaps in refill_valid are allowed.
  - On the accepted beat with beat==block_size-1:
    - write the tag, set the valid bit and update the replacement state;
    - refill_done=1 on the next cycle only;
    - go to IDLE, where refill_ready=0.
  - A lookup of the filled word therefore hits on the cycle refill_done is high.
  - invalidate_all during FILL aborts the fill: no refill_done, the victim stays invalid, go to INVAL.
  - refill_start in FILL or INVAL is ignored.
- INVAL:
  - A sweep counter clears the valid bits of every way of set i, one set per cycle, over cache_depth cycles (i=0..cache_depth-1).
  - After the last set, go to IDLE. Replacement state is reset to 0 in the final sweep cycle.
  - invalidate_all while in INVAL is ignored.
  - Lookups of already-swept sets miss. Unswept sets may still hit.
- Default replacement: a per-set round-robin pointer (way_bits wide, wraps ways-1 to 0), advanced only on refill commit.
- ways=1: victim is always way 0 and hit_way=0.

Optional Feature:
- Macro: ICACHE_PLRU_EN.
- Defined: per-set tree pseudo-LRU with ways-1 bits. It is updated toward "not this way" on every edge where lookup_valid&&hit, and on refill commit.
  - If a lookup hit and a commit land on the same set in the same cycle, the commit update wins.
  - Victim = PLRU leaf when all ways are valid.
- Undefined: round-robin as above; lookup_valid has no effect.

Test Plan:
- After reset, address=0x00000100 -> hit=0, instruction=0, busy=0, refill_ready=0.
- Refill set 0, tag 0x1234, beats 0x11,0x22,0x33,0x44 with a one-cycle refill_valid gap after beat 2 -> refill_done pulses for one cycle after the 4th beat. Fetching word 2 of that line returns instruction=0x33, hit=1, hit_way=0.
- Refill set 0 with tag 0x5678 -> fills way 1 and both tags hit. A third refill with tag 0x9ABC (round-robin) evicts way 0: 0x1234 misses, 0x5678 and 0x9ABC hit.
- Pulse invalidate_all with defaults -> busy=1 for exactly 64 cycles, then every address misses. A refill_start during busy produces no fill.
- Assert invalidate_all after 2 accepted beats -> refill_ready=0 next cycle, no refill_done, and the line misses after the sweep.
- Assert async reset mid-fill -> refill_ready and hit drop to 0 without waiting for a clock edge, and the state is IDLE after release. With ICACHE_PLRU_EN: fill ways 0,1, hit way 0, refill again -> victim is way 1.
